// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: block-fill controller for cache misses.
// Issues one word read per cycle for every word of the missing block, streams
// each returned word into the data array, and pulses the tag-array write on
// the last word so that the block becomes valid.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);

  localparam int CNT_W  = $clog2(WORDS);
  localparam int OFF_W  = CNT_W + 1;
  localparam int BASE_W = ADDR_W - OFF_W;
  localparam logic [CNT_W:0]   REQ_DONE = (CNT_W + 1)'(WORDS);
  localparam logic [CNT_W-1:0] RCV_LAST = CNT_W'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state;
  logic [BASE_W-1:0]   base;
  logic [CNT_W:0]      req_cnt;
  logic [CNT_W-1:0]    rcv_cnt;

  // The byte offset of the missing access does not matter: the whole block is filled.
  logic unused_offset;
  assign unused_offset = ^miss_address[OFF_W-1:0];

  // Latch the block on an accepted miss, then count requests issued and words received.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= miss_address[ADDR_W-1:OFF_W];
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (memory_read) begin
            req_cnt <= req_cnt + 1'b1;
          end
          if (memory_data_valid) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == RCV_LAST) begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Busy is a plain decode of the registered state.
  assign fsm_busy = (state == FILL);

  // Request/response strobes and word addresses; address outputs show the block base when idle.
  always_comb begin
    memory_read      = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    memory_address   = {base, {OFF_W{1'b0}}};
    fill_address     = {base, {OFF_W{1'b0}}};
    fill_data        = memory_data;
    if (state == FILL) begin
      memory_read      = (req_cnt < REQ_DONE);
      memory_address   = {base, req_cnt[CNT_W-1:0], 1'b0};
      fill_address     = {base, rcv_cnt, 1'b0};
      write_data_array = memory_data_valid;
      write_tag_array  = memory_data_valid && (rcv_cnt == RCV_LAST);
    end
  end

endmodule
